gb_cpu_interrupt_ctrl: RTL and testbench

//  Interrupt controller for the gameboy CPU. Holds IE (0xFFFF), IF (0xFF0F) and the IME flag.

---
 rtl/gb_cpu_interrupt_ctrl.sv | 152 +++++++++++++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller.
// Holds IE, IF and IME, latches peripheral requests, tracks EI/DI/RETI and
// sequences the dispatch handshake with the control unit. On dispatch it
// supplies the PC vector that the register file loads.
module gb_cpu_interrupt_ctrl #(
    parameter int unsigned NUM_IRQ  = 5,
    parameter logic [7:0]  VEC_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ie_wr,
    input  logic               if_wr,
    input  logic [7:0]         wr_data,
    output logic [7:0]         ie_q,
    output logic [7:0]         if_q,
    input  logic               instr_boundary,
    input  logic               ei_cmd,
    input  logic               di_cmd,
    input  logic               reti_cmd,
    input  logic               int_ack,
    input  logic               int_vec_sel,
    output logic               ime,
    output logic               int_pending,
    output logic               halt_wake,
    output logic               write_interrupt_vector,
    output logic [7:0]         interrupt_vector
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_VECTOR
    } state_t;

    state_t             state_q;
    logic [7:0]         ie_reg_q, ie_reg_d;
    logic [NUM_IRQ-1:0] if_reg_q, if_reg_d;
    logic               ime_q, ime_d;
    logic               ei_delay_q, ei_delay_d;
    logic [7:0]         vec_q;
    logic               wiv_q;

    logic [NUM_IRQ-1:0] pend_vec;
    logic               sel_hit;
    logic [NUM_IRQ-1:0] sel_mask;
    logic [7:0]         sel_vec;
    logic               vec_take;

    assign pend_vec = ie_reg_q[NUM_IRQ-1:0] & if_reg_q;
    assign vec_take = (state_q == S_DISPATCH) && int_vec_sel;

    // Lowest set bit of the pending vector wins (VBlank highest priority)
    always_comb begin
        sel_hit  = 1'b0;
        sel_mask = '0;
        sel_vec  = 8'h00;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend_vec[i] && !sel_hit) begin
                sel_hit     = 1'b1;
                sel_mask[i] = 1'b1;
                sel_vec     = VEC_BASE + 8'(i * 8);
            end
        end
    end

    // Next-state for IE, IF and the IME/EI-delay pair
    always_comb begin
        ie_reg_d = ie_wr ? wr_data : ie_reg_q;

        // Write, then dispatch clear, then OR in new requests so none is lost
        if_reg_d = if_wr ? wr_data[NUM_IRQ-1:0] : if_reg_q;
        if (vec_take) begin
            if_reg_d = if_reg_d & ~sel_mask;
        end
        if_reg_d = if_reg_d | irq_in;

        ime_d      = ime_q;
        ei_delay_d = ei_delay_q;
        if (int_ack || di_cmd) begin
            ime_d      = 1'b0;
            ei_delay_d = 1'b0;
        end else if (reti_cmd) begin
            ime_d      = 1'b1;
            ei_delay_d = 1'b0;
        end else begin
            // ei_delay_q is registered, so a boundary in the EI cycle itself never counts
            if (ei_delay_q && instr_boundary) begin
                ime_d      = 1'b1;
                ei_delay_d = 1'b0;
            end
            if (ei_cmd) begin
                ei_delay_d = 1'b1;
            end
        end
    end

    // Architectural register state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ie_reg_q   <= '0;
            if_reg_q   <= '0;
            ime_q      <= 1'b0;
            ei_delay_q <= 1'b0;
        end else begin
            ie_reg_q   <= ie_reg_d;
            if_reg_q   <= if_reg_d;
            ime_q      <= ime_d;
            ei_delay_q <= ei_delay_d;
        end
    end

    // Dispatch FSM with registered vector and one-cycle write pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            wiv_q   <= 1'b0;
        end else begin
            wiv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (int_ack && int_pending) begin
                        state_q <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (int_vec_sel) begin
                        state_q <= S_VECTOR;
                        vec_q   <= sel_hit ? sel_vec : 8'h00;
                        wiv_q   <= 1'b1;
                    end
                end
                S_VECTOR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ie_q                   = ie_reg_q;
    assign if_q                   = {{(8 - NUM_IRQ){1'b1}}, if_reg_q};
    assign ime                    = ime_q;
    assign halt_wake              = |pend_vec;
    assign int_pending            = ime_q && (|pend_vec) && (state_q == S_IDLE);
    assign write_interrupt_vector = wiv_q;
    assign interrupt_vector       = vec_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl: a behavioural model of the
// interrupt rules is compared against the DUT every cycle, and directed
// scenarios carry hand-computed literal expectations.
module tb_gb_cpu_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [4:0] irq_in = '0;
    logic       ie_wr = 1'b0, if_wr = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] ie_q, if_q;
    logic       instr_boundary = 1'b0, ei_cmd = 1'b0, di_cmd = 1'b0, reti_cmd = 1'b0;
    logic       int_ack = 1'b0, int_vec_sel = 1'b0;
    logic       ime, int_pending, halt_wake, write_interrupt_vector;
    logic [7:0] interrupt_vector;

    int checks = 0;
    int failures = 0;

    gb_cpu_interrupt_ctrl #(.NUM_IRQ(5), .VEC_BASE(8'h40)) dut (
        .clk(clk), .reset_n(reset_n), .irq_in(irq_in),
        .ie_wr(ie_wr), .if_wr(if_wr), .wr_data(wr_data),
        .ie_q(ie_q), .if_q(if_q),
        .instr_boundary(instr_boundary), .ei_cmd(ei_cmd), .di_cmd(di_cmd),
        .reti_cmd(reti_cmd), .int_ack(int_ack), .int_vec_sel(int_vec_sel),
        .ime(ime), .int_pending(int_pending), .halt_wake(halt_wake),
        .write_interrupt_vector(write_interrupt_vector),
        .interrupt_vector(interrupt_vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_valid = 0;
    int       m_ie, m_if;          // plain integers holding register contents
    bit       m_ime, m_armed;      // armed = EI seen, waiting for a later boundary
    int       m_phase;             // 0 idle, 1 waiting for vector select, 2 pulse cycle
    int       m_vec;

    function automatic int lowest_pending(input int ie_v, input int if_v);
        for (int n = 0; n < 5; n++)
            if (((ie_v >> n) & 1) == 1 && ((if_v >> n) & 1) == 1) return n;
        return -1;
    endfunction

    always @(posedge clk) begin
        int n, nif;
        bit nime, narm;
        if (!reset_n) begin
            m_valid = 1; m_ie = 0; m_if = 0; m_ime = 0; m_armed = 0;
            m_phase = 0; m_vec = 0;
        end else if (m_valid) begin
            n   = lowest_pending(m_ie, m_if);
            nif = if_wr ? int'(wr_data) % 32 : m_if;
            if (m_phase == 1 && int_vec_sel) begin
                if (n >= 0) begin
                    nif   = nif & ~(1 << n);
                    m_vec = 64 + 8 * n;
                end else begin
                    m_vec = 0;
                end
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 0 && int_ack && m_ime && n >= 0) begin
                m_phase = 1;
            end
            nif = nif | int'(irq_in);
            if (ie_wr) m_ie = int'(wr_data);

            nime = m_ime; narm = m_armed;
            if (ei_cmd) narm = 1;
            if (m_armed && instr_boundary) begin nime = 1; narm = ei_cmd; end
            if (reti_cmd) begin nime = 1; narm = 0; end
            if (di_cmd)   begin nime = 0; narm = 0; end
            if (int_ack)  begin nime = 0; narm = 0; end
            m_ime = nime; m_armed = narm; m_if = nif;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ie_q", ie_q, 8'(m_ie));
            chk("if_q", if_q, 8'(224 + m_if));
            chk("ime", {7'd0, ime}, {7'd0, m_ime});
            chk("halt_wake", {7'd0, halt_wake}, {7'd0, lowest_pending(m_ie, m_if) >= 0});
            chk("int_pending", {7'd0, int_pending},
                {7'd0, m_ime && m_phase == 0 && lowest_pending(m_ie, m_if) >= 0});
            chk("wiv", {7'd0, write_interrupt_vector}, {7'd0, m_phase == 2});
            chk("vector", interrupt_vector, 8'(m_vec));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk); #2;
        irq_in = '0; ie_wr = 0; if_wr = 0; wr_data = '0;
        instr_boundary = 0; ei_cmd = 0; di_cmd = 0; reti_cmd = 0;
        int_ack = 0; int_vec_sel = 0;
    endtask

    initial begin
        // 1. reset
        reset_n = 0; cyc(); cyc(); reset_n = 1;
        chk("rst_ie", ie_q, 8'h00);
        chk("rst_if", if_q, 8'hE0);
        chk("rst_ime", {7'd0, ime}, 8'h00);
        chk("rst_wiv", {7'd0, write_interrupt_vector}, 8'h00);
        chk("rst_vec", interrupt_vector, 8'h00);
        chk("rst_pend", {7'd0, int_pending}, 8'h00);

        // 2. priority: IE=1F, IF=14 -> source 2 wins, vector 0x50
        ie_wr = 1; wr_data = 8'h1F; cyc();
        if_wr = 1; wr_data = 8'h14; cyc();
        reti_cmd = 1; cyc();
        chk("p_pend", {7'd0, int_pending}, 8'h01);
        int_ack = 1; cyc();
        chk("p_ime_ack", {7'd0, ime}, 8'h00);
        cyc(); cyc();
        int_vec_sel = 1; cyc();
        chk("p_wiv", {7'd0, write_interrupt_vector}, 8'h01);
        chk("p_vec", interrupt_vector, 8'h50);
        chk("p_if", if_q, 8'hF0);
        cyc();
        chk("p_wiv_end", {7'd0, write_interrupt_vector}, 8'h00);
        chk("p_vec_hold", interrupt_vector, 8'h50);

        // 3. EI delay
        ei_cmd = 1; instr_boundary = 1; cyc();
        chk("ei_same", {7'd0, ime}, 8'h00);
        cyc();
        chk("ei_wait", {7'd0, ime}, 8'h00);
        instr_boundary = 1; cyc();
        chk("ei_set", {7'd0, ime}, 8'h01);
        di_cmd = 1; cyc();
        chk("di_clr", {7'd0, ime}, 8'h00);
        ei_cmd = 1; cyc();
        di_cmd = 1; cyc();
        instr_boundary = 1; cyc();
        chk("ei_di", {7'd0, ime}, 8'h00);

        // 4. cancel: IF cleared during push -> vector 00, single pulse
        ie_wr = 1; wr_data = 8'h04; cyc();
        if_wr = 1; wr_data = 8'h04; cyc();
        reti_cmd = 1; cyc();
        int_ack = 1; cyc();
        if_wr = 1; wr_data = 8'h00; cyc();
        int_vec_sel = 1; cyc();
        chk("c_wiv", {7'd0, write_interrupt_vector}, 8'h01);
        chk("c_vec", interrupt_vector, 8'h00);
        chk("c_if", if_q, 8'hE0);
        int_vec_sel = 1; cyc();
        chk("c_once", {7'd0, write_interrupt_vector}, 8'h00);

        // 5. races with incoming requests
        if_wr = 1; wr_data = 8'h00; irq_in = 5'h01; cyc();
        chk("r_wr", if_q, 8'hE1);
        ie_wr = 1; wr_data = 8'h01; cyc();
        reti_cmd = 1; cyc();
        int_ack = 1; cyc();
        int_vec_sel = 1; irq_in = 5'h01; cyc();
        chk("r_vec", interrupt_vector, 8'h40);
        chk("r_if", if_q, 8'hE1);

        // 6. halt_wake independent of IME; reset during dispatch
        if_wr = 1; wr_data = 8'h00; cyc();
        ie_wr = 1; wr_data = 8'h08; cyc();
        irq_in = 5'h08; cyc();
        chk("h_wake", {7'd0, halt_wake}, 8'h01);
        chk("h_pend", {7'd0, int_pending}, 8'h00);
        reti_cmd = 1; cyc();
        int_ack = 1; cyc();
        reset_n = 0; cyc();
        reset_n = 1; int_vec_sel = 1; cyc();
        chk("rd_wiv", {7'd0, write_interrupt_vector}, 8'h00);
        chk("rd_if", if_q, 8'hE0);
        cyc(); cyc();
        chk("rd_wiv2", {7'd0, write_interrupt_vector}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
